hamming_decode: RTL

SECDED (extended Hamming) decoder, the receive-side counterpart to the team's Hamming encoder. It accepts CODED_WIDTH-bit codewords over a valid/ready handshake and computes syndrome and overall parity. It corrects single-bit errors, flags double-bit errors, and returns DATA_WIDTH-bit data with status through a 2-stage registered pipeline. Saturating error counters support link/memory health monitoring.

---
 rtl/hamming_decode_pkg.sv | 44 ++++
 rtl/hamming_syndrome.sv | 21 ++
 rtl/hamming_decode.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hamming_decode_pkg.sv
// Shared SECDED codeword layout helpers and decode status, used by encoder and decoder alike.
package hamming_decode_pkg;

   typedef enum logic [1:0] {
      StatClean,
      StatCorrected,
      StatUncorrectable
   } status_e;

   // Smallest P with 2^P >= data_width + P + 1.
   function automatic int unsigned parity_width(input int unsigned data_width);
      int unsigned p;
      p = 0;
      for (int unsigned i = 31; i > 0; i--) begin
         if ((32'd1 << i) >= data_width + i + 1) p = i;
      end
      return p;
   endfunction

   function automatic int unsigned coded_width(input int unsigned data_width);
      return data_width + parity_width(data_width) + 1;
   endfunction

   // Position 0 (overall parity) and every power of two hold check bits.
   function automatic logic is_parity_pos(input int unsigned pos);
      return (pos & (pos - 1)) == 0;
   endfunction

   // Codeword position of data bit k (data fills non-parity slots in ascending order).
   function automatic int unsigned data_pos(input int unsigned k);
      int unsigned n;
      int unsigned pos;
      n   = 0;
      pos = 0;
      for (int unsigned i = 1; i < 1024; i++) begin
         if (!is_parity_pos(i)) begin
            if (n == k && pos == 0) pos = i;
            n++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of a SECDED codeword.
module hamming_syndrome #(
   parameter int unsigned CODED_WIDTH  = 39,
   parameter int unsigned PARITY_WIDTH = 6
) (
   input  logic [CODED_WIDTH-1:0]  code_i,
   output logic [PARITY_WIDTH-1:0] syndrome_o,
   output logic                    parity_o
);

   // Syndrome is the XOR of the indices of every set bit above the overall-parity bit.
   always_comb begin
      syndrome_o = '0;
      for (int unsigned i = 1; i < CODED_WIDTH; i++) begin
         if (code_i[i]) syndrome_o = syndrome_o ^ PARITY_WIDTH'(i);
      end
   end

   assign parity_o = ^code_i;

endmodule

// File: rtl/hamming_decode.sv
// Two-stage pipelined SECDED decoder with valid/ready handshake and saturating error counters.
module hamming_decode
   import hamming_decode_pkg::*;
#(
   parameter int unsigned  DATA_WIDTH   = 32,
   parameter int unsigned  CNT_WIDTH    = 16,
   localparam int unsigned PARITY_WIDTH = parity_width(DATA_WIDTH),
   localparam int unsigned CODED_WIDTH  = coded_width(DATA_WIDTH)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [CODED_WIDTH-1:0]  code_in_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [DATA_WIDTH-1:0]   data_out_o,
   output logic                    corrected_o,
   output logic                    uncorrectable_o,
   output logic [PARITY_WIDTH-1:0] syndrome_o,
   input  logic                    clr_cnt_i,
   output logic [CNT_WIDTH-1:0]    corr_cnt_o,
   output logic [CNT_WIDTH-1:0]    uncorr_cnt_o
);

   logic                    s1_valid_q;
   logic [DATA_WIDTH-1:0]   s1_data_q;
   logic [PARITY_WIDTH-1:0] s1_syn_q;
   logic                    s1_par_q;

   logic                    s2_valid_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    corrected_q;
   logic                    uncorr_q;
   logic [PARITY_WIDTH-1:0] syn_q;

   logic [CNT_WIDTH-1:0]    corr_cnt_q, corr_cnt_d;
   logic [CNT_WIDTH-1:0]    uncorr_cnt_q, uncorr_cnt_d;

   logic                    s1_adv, s2_adv, out_fire;
   logic [PARITY_WIDTH-1:0] in_syn;
   logic                    in_par;
   logic [DATA_WIDTH-1:0]   in_data;
   logic [DATA_WIDTH-1:0]   s1_flip;
   logic [DATA_WIDTH-1:0]   data_fix;
   status_e                 s1_status;

   assign s2_adv     = !s2_valid_q || out_ready_i;
   assign s1_adv     = !s1_valid_q || s2_adv;
   assign out_fire   = s2_valid_q && out_ready_i;
   assign in_ready_o = s1_adv;

   hamming_syndrome #(
      .CODED_WIDTH (CODED_WIDTH),
      .PARITY_WIDTH(PARITY_WIDTH)
   ) u_syndrome (
      .code_i    (code_in_i),
      .syndrome_o(in_syn),
      .parity_o  (in_par)
   );

   // Only the data field is carried forward; a flip is applied where the syndrome
   // names a data position. Check-bit flips leave the payload untouched.
   for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_data
      localparam int unsigned Pos = data_pos(k);
      assign in_data[k] = code_in_i[Pos];
      assign s1_flip[k] = (s1_syn_q == PARITY_WIDTH'(Pos));
   end

   always_comb begin
      s1_status = StatClean;
      if (s1_par_q) begin
         if (32'(s1_syn_q) < CODED_WIDTH) s1_status = StatCorrected;
         else                             s1_status = StatUncorrectable;
      end else if (s1_syn_q != '0) begin
         s1_status = StatUncorrectable;
      end
   end

   assign data_fix = (s1_status == StatCorrected) ? (s1_data_q ^ s1_flip) : s1_data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_syn_q    <= '0;
         s1_par_q    <= 1'b0;
         s2_valid_q  <= 1'b0;
         data_q      <= '0;
         corrected_q <= 1'b0;
         uncorr_q    <= 1'b0;
         syn_q       <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
               s1_data_q <= in_data;
               s1_syn_q  <= in_syn;
               s1_par_q  <= in_par;
            end
         end
         if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               data_q      <= data_fix;
               corrected_q <= (s1_status == StatCorrected);
               uncorr_q    <= (s1_status == StatUncorrectable);
               syn_q       <= s1_syn_q;
            end
         end
      end
   end

   // Clear wins over a same-cycle increment; counts stick at all-ones.
   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (clr_cnt_i) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else if (out_fire) begin
         if (corrected_q && corr_cnt_q != '1)  corr_cnt_d   = corr_cnt_q + 1'b1;
         if (uncorr_q && uncorr_cnt_q != '1)   uncorr_cnt_d = uncorr_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign out_valid_o     = s2_valid_q;
   assign data_out_o      = data_q;
   assign corrected_o     = corrected_q;
   assign uncorrectable_o = uncorr_q;
   assign syndrome_o      = syn_q;
   assign corr_cnt_o      = corr_cnt_q;
   assign uncorr_cnt_o    = uncorr_cnt_q;

endmodule
